// File: rtl/bcd_down_counter_4d.sv
// -----------------------------------------------------------------------------
// bcd_down_counter_4d
//
// Four-digit packed-BCD down-counter. This is the countdown/timer engine that
// sits beside the four-digit decimal up-counter and feeds the display path.
// The count is preset with a parallel load and then decremented once per
// enabled clock. Each digit borrows from the next one up when it rolls 0 -> 9.
//
// Parameters
//   STOP_AT_ZERO : 1 = hold at 0000 once reached, 0 = wrap 0000 -> 9999
//   RESET_VAL    : packed BCD value loaded on reset (nibbles 0-9)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   load     in   parallel load strobe (has priority over en)
//   load_val in   [15:0] packed BCD preset, [3:0] ones ... [15:12] thousands
//   en       in   count enable, decrement by one this cycle
//   q        out  [15:0] registered packed BCD count
//   brw      out  [3:1] combinational borrow enables, brw[i] = digit i
//                 decrements on this edge
//   zero     out  registered, high while q == 0000
//   done     out  registered one-cycle pulse when counting reaches 0000
// -----------------------------------------------------------------------------
module bcd_down_counter_4d #(
  parameter bit          STOP_AT_ZERO = 1'b1,
  parameter logic [15:0] RESET_VAL    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic [15:0] q,
  output logic [3:1]  brw,
  output logic        zero,
  output logic        done
);

  // Forces every nibble into 0-9 so the count can never hold a non-BCD digit.
  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [3:0] dec_digit(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Reset value goes through the same clamp as a load, so even a bad
  // parameter override cannot put an invalid digit on the display.
  localparam logic [15:0] RESET_Q = clamp_bcd(RESET_VAL);

  logic        q_is_zero;
  logic        count_active;
  logic [3:0]  dig_dec;
  logic [15:0] q_dec;
  logic [15:0] load_q;

  always_comb begin
    q_is_zero    = (q == 16'h0000);
    // Reset gates the count so brw reads 000 while reset is held.
    count_active = en && !load && !reset && !(STOP_AT_ZERO && q_is_zero);

    brw    = 3'b000;
    brw[1] = count_active && (q[3:0]  == 4'd0);
    brw[2] = brw[1]       && (q[7:4]  == 4'd0);
    brw[3] = brw[2]       && (q[11:8] == 4'd0);

    // Ones digit moves on every active count; higher digits on their borrow.
    dig_dec = {brw, count_active};

    q_dec = q;
    for (int i = 0; i < 4; i++) begin
      if (dig_dec[i]) q_dec[4*i +: 4] = dec_digit(q[4*i +: 4]);
    end

    load_q = clamp_bcd(load_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= RESET_Q;
      zero <= (RESET_Q == 16'h0000);
      done <= 1'b0;
    end else if (load) begin
      q    <= load_q;
      zero <= (load_q == 16'h0000);
      done <= 1'b0;
    end else if (count_active) begin
      q    <= q_dec;
      zero <= (q_dec == 16'h0000);
      // A decrement only lands on 0000 when coming from 0001 (0000 itself
      // goes to 9999 or is not counted), so this marks the arrival.
      done <= (q_dec == 16'h0000);
    end else begin
      done <= 1'b0;
    end
  end

endmodule
